// File: rtl/commit_trace_buffer_if.sv
// Commit/trace bundle between the retire port, the trace consumer and the
// pipeline control unit. The buffer itself sits on the slave side.
interface commit_trace_buffer_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16
);
  logic                     commit;
  logic [31:0]              commit_instr;
  logic [XLEN-1:0]          commit_pc;
  logic [XLEN-1:0]          commit_pre_pc;
  logic                     trace_valid;
  logic                     trace_ready;
  logic [31:0]              trace_instr;
  logic [XLEN-1:0]          trace_pc;
  logic [XLEN-1:0]          trace_pre_pc;
  logic [XLEN-1:0]          trace_cycle;
  logic [XLEN-1:0]          trace_seq;
  logic                     stall_req;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   occupancy;
  logic [XLEN-1:0]          cycle_cnt;
  logic [XLEN-1:0]          instret_cnt;

  modport master (
    output commit, commit_instr, commit_pc, commit_pre_pc, trace_ready,
    input  trace_valid, trace_instr, trace_pc, trace_pre_pc, trace_cycle,
           trace_seq, stall_req, overflow, occupancy, cycle_cnt, instret_cnt
  );

  modport slave (
    input  commit, commit_instr, commit_pc, commit_pre_pc, trace_ready,
    output trace_valid, trace_instr, trace_pc, trace_pre_pc, trace_cycle,
           trace_seq, stall_req, overflow, occupancy, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit-stream capture FIFO. Each retired instruction is stored together
// with the cycle count and retire sequence number current at the push edge.
// Fullness comes from the occupancy counter; pointers simply wrap. The stall
// request is raised early enough (SKID entries of headroom) that commits
// already in flight still fit.
module commit_trace_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int SKID  = 4
) (
  input logic                  clk,
  input logic                  rst,
  commit_trace_buffer_if.slave bus
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int OccW = PtrW + 1;
  localparam logic [OccW-1:0] OccFull  = OccW'(DEPTH);
  localparam logic [OccW-1:0] OccStall = OccW'(DEPTH - SKID);

  logic [31:0]     memInstr [DEPTH];
  logic [XLEN-1:0] memPc    [DEPTH];
  logic [XLEN-1:0] memPrePc [DEPTH];
  logic [XLEN-1:0] memCycle [DEPTH];
  logic [XLEN-1:0] memSeq   [DEPTH];

  logic [PtrW-1:0] wrPtr;
  logic [PtrW-1:0] rdPtr;
  logic [OccW-1:0] occ;
  logic [OccW-1:0] occNext;
  logic [XLEN-1:0] cycleCnt;
  logic [XLEN-1:0] instretCnt;
  logic            overflowQ;
  logic            stallQ;
  logic            valid;
  logic            push;
  logic            pop;

  // Handshake decode and next-state occupancy; a push into a full FIFO is
  // allowed only when the head leaves in the same cycle.
  always_comb begin
    valid   = (occ != '0);
    pop     = valid && bus.trace_ready;
    push    = bus.commit && ((occ < OccFull) || pop);
    occNext = occ;
    case ({push, pop})
      2'b10:   occNext = occ + OccW'(1);
      2'b01:   occNext = occ - OccW'(1);
      default: occNext = occ;
    endcase
  end

  // Entry storage; contents need no reset because reads are gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      memInstr[wrPtr] <= bus.commit_instr;
      memPc[wrPtr]    <= bus.commit_pc;
      memPrePc[wrPtr] <= bus.commit_pre_pc;
      memCycle[wrPtr] <= cycleCnt;
      memSeq[wrPtr]   <= instretCnt;
    end
  end

  // Pointers, counters, sticky overflow and the early stall request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      occ        <= '0;
      cycleCnt   <= '0;
      instretCnt <= '0;
      overflowQ  <= 1'b0;
      stallQ     <= 1'b0;
    end else begin
      cycleCnt <= cycleCnt + XLEN'(1);
      occ      <= occNext;
      stallQ   <= (occNext >= OccStall);
      if (push) begin
        wrPtr      <= wrPtr + PtrW'(1);
        instretCnt <= instretCnt + XLEN'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      if (bus.commit && !push) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign bus.trace_valid  = valid;
  assign bus.trace_instr  = valid ? memInstr[rdPtr] : '0;
  assign bus.trace_pc     = valid ? memPc[rdPtr]    : '0;
  assign bus.trace_pre_pc = valid ? memPrePc[rdPtr] : '0;
  assign bus.trace_cycle  = valid ? memCycle[rdPtr] : '0;
  assign bus.trace_seq    = valid ? memSeq[rdPtr]   : '0;
  assign bus.stall_req    = stallQ;
  assign bus.overflow     = overflowQ;
  assign bus.occupancy    = occ;
  assign bus.cycle_cnt    = cycleCnt;
  assign bus.instret_cnt  = instretCnt;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench: a 64-bit, 16-deep buffer for the FIFO behaviour and an
// 8-bit, 4-deep buffer for counter rollover.
module tb_commit_trace_buffer;
  logic clk = 1'b0;
  logic rst;
  logic rstB;
  int   assertCnt = 0;
  int   failCnt = 0;
  int   pushed;
  int   popped;

  always #5 clk = ~clk;

  commit_trace_buffer_if #(.XLEN(64), .DEPTH(16)) busA ();
  commit_trace_buffer_if #(.XLEN(8),  .DEPTH(4))  busB ();

  commit_trace_buffer #(.XLEN(64), .DEPTH(16), .SKID(4)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  commit_trace_buffer #(.XLEN(8), .DEPTH(4), .SKID(1)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCnt++;
    assert (got === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pcOf(input int s);
    return 64'h1000 + 64'(s) * 64'd4;
  endfunction

  task automatic drivePush(input int s);
    busA.commit        = 1'b1;
    busA.commit_instr  = 32'(s) ^ 32'h0000_0013;
    busA.commit_pc     = pcOf(s);
    busA.commit_pre_pc = pcOf(s) - 64'd4;
  endtask

  // Reset released on the falling edge; leaves the sample point after the
  // first rising edge, with cycle_cnt = 1.
  task automatic doReset();
    busA.commit      = 1'b0;
    busA.trace_ready = 1'b0;
    rst = 1'b0;
    #4;
    rst = 1'b1;
    step();
  endtask

  task automatic fillFull();
    for (int i = 0; i < 16; i++) begin
      drivePush(i);
      step();
      check("fill_occ", 64'(busA.occupancy), 64'(i + 1));
      check("fill_stall", 64'(busA.stall_req), ((i + 1) >= 12) ? 64'd1 : 64'd0);
    end
    busA.commit = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    rstB = 1'b0;
    busA.commit = 1'b0; busA.commit_instr = '0; busA.commit_pc = '0;
    busA.commit_pre_pc = '0; busA.trace_ready = 1'b0;
    busB.commit = 1'b0; busB.commit_instr = '0; busB.commit_pc = '0;
    busB.commit_pre_pc = '0; busB.trace_ready = 1'b0;
    step();
    step();
    rst = 1'b1;

    check("rst_occ",     64'(busA.occupancy), 64'd0);
    check("rst_valid",   64'(busA.trace_valid), 64'd0);
    check("rst_stall",   64'(busA.stall_req), 64'd0);
    check("rst_ovf",     64'(busA.overflow), 64'd0);
    check("rst_cycle",   busA.cycle_cnt, 64'd0);
    check("rst_instret", busA.instret_cnt, 64'd0);
    check("rst_tpc",     busA.trace_pc, 64'd0);

    // single commit into the empty FIFO at cycle 3
    step(); step(); step();
    check("cycle3", busA.cycle_cnt, 64'd3);
    busA.commit = 1'b1; busA.commit_instr = 32'h0000_0013;
    busA.commit_pc = 64'h8000_0000; busA.commit_pre_pc = 64'h7fff_fffc;
    step();
    busA.commit = 1'b0;
    check("one_valid",   64'(busA.trace_valid), 64'd1);
    check("one_pc",      busA.trace_pc, 64'h8000_0000);
    check("one_prepc",   busA.trace_pre_pc, 64'h7fff_fffc);
    check("one_instr",   64'(busA.trace_instr), 64'h13);
    check("one_cycle",   busA.trace_cycle, 64'd3);
    check("one_seq",     busA.trace_seq, 64'd0);
    check("one_occ",     64'(busA.occupancy), 64'd1);
    check("one_instret", busA.instret_cnt, 64'd1);
    step();
    check("hold_valid", 64'(busA.trace_valid), 64'd1);
    check("hold_pc",    busA.trace_pc, 64'h8000_0000);
    check("hold_occ",   64'(busA.occupancy), 64'd1);

    // five entries held, then asynchronous reset between edges
    for (int i = 1; i < 5; i++) begin
      drivePush(i);
      step();
    end
    busA.commit = 1'b0;
    check("five_occ", 64'(busA.occupancy), 64'd5);
    check("five_head", busA.trace_pc, 64'h8000_0000);
    #2;
    rst = 1'b0;
    #1;
    check("arst_occ",   64'(busA.occupancy), 64'd0);
    check("arst_valid", 64'(busA.trace_valid), 64'd0);
    check("arst_ovf",   64'(busA.overflow), 64'd0);
    check("arst_cycle", busA.cycle_cnt, 64'd0);
    check("arst_stall", 64'(busA.stall_req), 64'd0);
    check("arst_tpc",   busA.trace_pc, 64'd0);
    #1;
    rst = 1'b1;
    step();

    // fill to full, then a dropped commit
    fillFull();
    drivePush(16);
    step();
    busA.commit = 1'b0;
    check("drop_ovf",     64'(busA.overflow), 64'd1);
    check("drop_occ",     64'(busA.occupancy), 64'd16);
    check("drop_instret", busA.instret_cnt, 64'd16);
    check("drop_head",    busA.trace_seq, 64'd0);
    step();
    check("ovf_sticky", 64'(busA.overflow), 64'd1);

    // full with simultaneous push and pop
    doReset();
    check("rst2_ovf", 64'(busA.overflow), 64'd0);
    fillFull();
    busA.trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drivePush(16 + k);
      check("pp_seq", busA.trace_seq, 64'(k));
      check("pp_pc",  busA.trace_pc, pcOf(k));
      step();
      check("pp_occ", 64'(busA.occupancy), 64'd16);
    end
    busA.commit = 1'b0;
    check("pp_ovf",     64'(busA.overflow), 64'd0);
    check("pp_instret", busA.instret_cnt, 64'd24);
    for (int k = 0; k < 16; k++) begin
      check("drain_seq",   busA.trace_seq, 64'(8 + k));
      check("drain_pc",    busA.trace_pc, pcOf(8 + k));
      check("drain_cycle_instr", 64'(busA.trace_instr), 64'(32'(8 + k) ^ 32'h13));
      step();
    end
    busA.trace_ready = 1'b0;
    check("drain_valid", 64'(busA.trace_valid), 64'd0);
    check("drain_occ",   64'(busA.occupancy), 64'd0);
    check("drain_stall", 64'(busA.stall_req), 64'd0);

    // 40-commit stream across pointer wrap, pipeline obeying stall_req
    doReset();
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 300 && popped < 40; c++) begin
      busA.trace_ready = (c % 2 == 0);
      if (pushed < 40 && !busA.stall_req) begin
        drivePush(pushed);
        pushed++;
      end else begin
        busA.commit = 1'b0;
      end
      if (busA.trace_valid && busA.trace_ready) begin
        check("wrap_seq", busA.trace_seq, 64'(popped));
        check("wrap_pc",  busA.trace_pc, pcOf(popped));
        popped++;
      end
      step();
    end
    busA.commit = 1'b0;
    busA.trace_ready = 1'b0;
    check("wrap_popped",  64'(popped), 64'd40);
    check("wrap_ovf",     64'(busA.overflow), 64'd0);
    check("wrap_occ",     64'(busA.occupancy), 64'd0);
    check("wrap_instret", busA.instret_cnt, 64'd40);

    // 8-bit counter rollover on the second instance
    rstB = 1'b1;
    busB.commit = 1'b1;
    busB.trace_ready = 1'b1;
    check("b_rst_cycle", 64'(busB.cycle_cnt), 64'd0);
    for (int c = 0; c < 300 && busB.cycle_cnt != 8'd255; c++) begin
      step();
    end
    check("b_reach255", 64'(busB.cycle_cnt), 64'd255);
    check("b_tc254",    64'(busB.trace_cycle), 64'd254);
    step();
    check("b_wrap",     64'(busB.cycle_cnt), 64'd0);
    check("b_tc255",    64'(busB.trace_cycle), 64'd255);
    check("b_seq255",   64'(busB.trace_seq), 64'd255);
    step();
    check("b_cycle1",   64'(busB.cycle_cnt), 64'd1);
    check("b_tc0",      64'(busB.trace_cycle), 64'd0);
    check("b_seq0",     64'(busB.trace_seq), 64'd0);
    check("b_occ",      64'(busB.occupancy), 64'd1);
    check("b_ovf",      64'(busB.overflow), 64'd0);
    busB.commit = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end
endmodule
